// File: rtl/matrix_pkg.sv
// Shared constants for the 3x3 matrix memory and its arbiter.
package matrix_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 2;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_A   = 2'd0;
    localparam logic [SEL_W-1:0] SEL_B   = 2'd1;
    localparam logic [SEL_W-1:0] SEL_C   = 2'd2;
    localparam logic [SEL_W-1:0] SEL_INV = 2'd3;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/matrix_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req strictly after ptr, wrapping.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // k == N wraps back to ptr itself, so the last holder is considered last
        for (int k = 1; k <= N; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/matrix_mem_arbiter.sv
// Round-robin arbiter for the shared A/B/C matrix memory with burst lock and hold limit.
// Optional MEM_ARB_STATS_EN adds a saturating stall_cnt output.
module matrix_mem_arbiter
    import matrix_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [SEL_W*NUM_REQ-1:0]  sel,
    input  logic [IDX_W*NUM_REQ-1:0]  row,
    input  logic [IDX_W*NUM_REQ-1:0]  col,
    input  logic [DATA_W*NUM_REQ-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [SEL_W-1:0]          mem_sel,
    output logic [IDX_W-1:0]          mem_row,
    output logic [IDX_W-1:0]          mem_col,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_e         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   own_idx;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;

    logic               own, access, o_req, o_lock, o_we, o_inv, others_pending, release_now;
    logic [SEL_W-1:0]   o_sel;

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        own            = (state == OWN);
        o_req          = req[own_idx];
        o_lock         = lock[own_idx];
        o_we           = we[own_idx];
        o_sel          = sel[int'(own_idx)*SEL_W +: SEL_W];
        o_inv          = (o_sel == SEL_INV);
        access         = own && o_req;
        others_pending = |(req & ~gnt);
        release_now    = own && ((!o_req && !o_lock) ||
                         (hold_cnt == HOLD_W'(MAX_HOLD - 1) && others_pending));

        mem_en    = access;
        mem_we    = access && o_we && !o_inv;
        mem_sel   = own ? o_sel : '0;
        mem_row   = own ? row[int'(own_idx)*IDX_W +: IDX_W] : '0;
        mem_col   = own ? col[int'(own_idx)*IDX_W +: IDX_W] : '0;
        mem_wdata = own ? wdata[int'(own_idx)*DATA_W +: DATA_W] : '0;
        rdata     = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            gnt      <= '0;
            rvalid   <= '0;
            err      <= 1'b0;
            hold_cnt <= '0;
            rr_ptr   <= PTR_W'(NUM_REQ - 1);
            own_idx  <= '0;
        end else begin
            // gnt is the owner's one-hot, so it doubles as the rvalid pattern
            rvalid <= (access && !o_we) ? gnt : '0;
            err    <= access && o_inv;
            case (state)
                ARB: begin
                    if (pick_valid) begin
                        gnt      <= pick;
                        own_idx  <= pick_idx;
                        rr_ptr   <= pick_idx;
                        hold_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        gnt   <= '0;
                        state <= ARB;
                    end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (|(req & ~gnt) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Directed bench for matrix_mem_arbiter (MAX_HOLD=4) with a small synchronous memory model.
// Define MEM_ARB_STATS_EN to also exercise stall_cnt.
module tb_matrix_mem_arbiter;
    import matrix_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]        req, lock, we, gnt, rvalid;
    logic [SEL_W*N-1:0]  sel;
    logic [IDX_W*N-1:0]  row, col;
    logic [DATA_W*N-1:0] wdata;
    logic [DATA_W-1:0]   rdata, mem_wdata, mem_rdata;
    logic                err, mem_en, mem_we;
    logic [SEL_W-1:0]    mem_sel;
    logic [IDX_W-1:0]    mem_row, mem_col;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]         stall_cnt;
`endif

    int nchk = 0;
    int nfail = 0;

    logic [7:0] mem [0:3][0:3][0:3];

    matrix_mem_arbiter #(.NUM_REQ(N), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .sel       (sel),
        .row       (row),
        .col       (col),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_row   (mem_row),
        .mem_col   (mem_col),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // memory: write on strobe, read data one cycle after the access
    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 4; s++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        mem[s][r][c] <= 8'h00;
            mem_rdata <= 8'h00;
        end else if (mem_en) begin
            if (mem_we)
                mem[mem_sel][mem_row][mem_col] <= mem_wdata;
            else
                mem_rdata <= mem[mem_sel][mem_row][mem_col];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_r(input int i, input logic r, input logic l, input logic w,
                         input logic [1:0] s, input logic [1:0] rw, input logic [1:0] cl,
                         input logic [7:0] d);
        req[i]          = r;
        lock[i]         = l;
        we[i]           = w;
        sel[i*2 +: 2]   = s;
        row[i*2 +: 2]   = rw;
        col[i*2 +: 2]   = cl;
        wdata[i*8 +: 8] = d;
    endtask

    initial begin
        req = '0; lock = '0; we = '0; sel = '0; row = '0; col = '0; wdata = '0;
        repeat (3) cyc();
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_en", 32'(mem_en), 0);

        // rotation with a dead cycle between owners
        reset = 1'b0;
        req = 3'b111;
        cyc(); chk("t1_g0", 32'(gnt), 1); req = 3'b110;
        cyc(); chk("t1_gap0", 32'(gnt), 0);
        cyc(); chk("t1_g1", 32'(gnt), 2); req = 3'b100;
        cyc(); chk("t1_gap1", 32'(gnt), 0);
        cyc(); chk("t1_g2", 32'(gnt), 4); req = 3'b000;
        cyc(); chk("t1_gap2", 32'(gnt), 0);

        // write 5A to B[1][2], read it back
        set_r(0, 1'b1, 1'b0, 1'b1, SEL_B, 2'd1, 2'd2, 8'h5A);
        cyc(); chk("t2_gnt", 32'(gnt), 1);
        #1 chk("t2_wr_we", 32'(mem_we), 1);
        cyc(); we[0] = 1'b0;
        #1;
        chk("t2_rd_en", 32'(mem_en), 1);
        chk("t2_rd_we", 32'(mem_we), 0);
        chk("t2_rd_sel", 32'(mem_sel), 1);
        chk("t2_rd_row", 32'(mem_row), 1);
        chk("t2_rd_col", 32'(mem_col), 2);
        cyc();
        chk("t2_rvalid", 32'(rvalid), 1);
        chk("t2_rdata", 32'(rdata), 32'h5A);
        req[0] = 1'b0;
        cyc();
        chk("t2_rv_clr", 32'(rvalid), 0);
        chk("t2_rel", 32'(gnt), 0);

        // locked writer preempted at the hold limit
        set_r(0, 1'b1, 1'b0, 1'b0, SEL_A, 2'd0, 2'd0, 8'h00);
        set_r(1, 1'b1, 1'b1, 1'b1, SEL_C, 2'd0, 2'd0, 8'h10);
        cyc(); chk("t3_gnt", 32'(gnt), 2);
        #1;
        chk("t3_we", 32'(mem_we), 1);
        chk("t3_own_mux", 32'(mem_sel), 32'(SEL_C));
        for (int k = 1; k <= 3; k++) begin
            cyc(); chk("t3_hold", 32'(gnt), 2);
            set_r(1, 1'b1, 1'b1, 1'b1, SEL_C, 2'(k / 3), 2'(k % 3), 8'(16 + k));
        end
        cyc(); chk("t3_preempt", 32'(gnt), 0);
        set_r(1, 1'b0, 1'b0, 1'b0, SEL_A, 2'd0, 2'd0, 8'h00);
        chk("t3_c00", 32'(mem[2][0][0]), 32'h10);
        chk("t3_c01", 32'(mem[2][0][1]), 32'h11);
        chk("t3_c02", 32'(mem[2][0][2]), 32'h12);
        chk("t3_c10", 32'(mem[2][1][0]), 32'h13);
        chk("t3_c11", 32'(mem[2][1][1]), 32'h00);
        cyc(); chk("t3_next", 32'(gnt), 1); req[0] = 1'b0;
        cyc(); chk("t3_rel", 32'(gnt), 0);

        // write to the invalid bank
        set_r(2, 1'b1, 1'b0, 1'b1, SEL_INV, 2'd0, 2'd0, 8'hFF);
        cyc(); chk("t4_gnt", 32'(gnt), 4);
        #1;
        chk("t4_en", 32'(mem_en), 1);
        chk("t4_we", 32'(mem_we), 0);
        cyc();
        chk("t4_err", 32'(err), 1);
        chk("t4_rvalid", 32'(rvalid), 0);
        req[2] = 1'b0;
        cyc();
        chk("t4_err_clr", 32'(err), 0);
        chk("t4_rel", 32'(gnt), 0);
        chk("t4_inv_mem", 32'(mem[3][0][0]), 0);
        chk("t4_c00", 32'(mem[2][0][0]), 32'h10);

        // reset in the middle of a locked read burst
        set_r(0, 1'b1, 1'b1, 1'b0, SEL_A, 2'd0, 2'd0, 8'h00);
        cyc(); chk("t5_gnt0", 32'(gnt), 1); reset = 1'b1;
        cyc();
        chk("t5_rst_gnt", 32'(gnt), 0);
        chk("t5_rst_rvalid", 32'(rvalid), 0);
        #1 chk("t5_rst_en", 32'(mem_en), 0);
        reset = 1'b0;
        set_r(0, 1'b0, 1'b0, 1'b0, SEL_A, 2'd0, 2'd0, 8'h00);
        set_r(1, 1'b1, 1'b0, 1'b0, SEL_A, 2'd0, 2'd0, 8'h00);
        set_r(2, 1'b1, 1'b0, 1'b0, SEL_A, 2'd0, 2'd0, 8'h00);
        cyc(); chk("t5_gnt1", 32'(gnt), 2); req[2] = 1'b0;

        // sole requester runs past the hold limit
        for (int k = 0; k < 8; k++) begin
            cyc(); chk("sole_hold", 32'(gnt), 2);
        end
        req = '0;
        cyc(); chk("sole_rel", 32'(gnt), 0);

`ifdef MEM_ARB_STATS_EN
        reset = 1'b1;
        cyc(); chk("t6_rst", 32'(stall_cnt), 0);
        reset = 1'b0;
        set_r(0, 1'b1, 1'b0, 1'b0, SEL_A, 2'd0, 2'd0, 8'h00);
        set_r(1, 1'b1, 1'b0, 1'b0, SEL_A, 2'd0, 2'd0, 8'h00);
        repeat (10) cyc();
        chk("t6_stall10", 32'(stall_cnt), 10);
        repeat (70000) cyc();
        chk("t6_sat", 32'(stall_cnt), 32'hFFFF);
        req = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
